// File: rtl/rf_pkg.sv
// Shared defaults and address-width helper for the scoreboarded register file.
package rf_pkg;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned NREGS_DEF  = 8;

   function automatic int unsigned aw_of(input int unsigned n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/rf_sb_entry.sv
// One register-file entry: data word plus its pending (outstanding-write) bit.
module rf_sb_entry
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr,
   input  logic              rsv,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] data,
   output logic              pend
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
         pend <= 1'b0;
      end else begin
         if (wr) data <= wr_data;
         // A new reservation outranks a completing write in the same cycle.
         if (rsv)     pend <= 1'b1;
         else if (wr) pend <= 1'b0;
      end
   end

endmodule

// File: rtl/rf_sb.sv
// Register file with per-register pending bits, write-to-read bypass and a
// registered protocol-error pulse.
module rf_sb
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned NREGS   = NREGS_DEF,
   parameter bit          ZERO_R0 = 1'b0,
   localparam int unsigned AW     = aw_of(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [AW-1:0]     rd1_sel,
   input  logic [AW-1:0]     rd2_sel,
   output logic [DATA_W-1:0] rd1_data,
   output logic [DATA_W-1:0] rd2_data,
   output logic              rd1_pend,
   output logic              rd2_pend,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_sel,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rsv_en,
   input  logic [AW-1:0]     rsv_sel,
   output logic [NREGS-1:0]  pend_vec,
   output logic              err
);

   logic [DATA_W-1:0] regs [NREGS];
   logic [NREGS-1:0]  pend_bits;
   logic [NREGS-1:0]  wr_hit;
   logic [NREGS-1:0]  rsv_hit;
   logic              byp1;
   logic              byp2;
   logic              wr_ok;
   logic              rsv_ok;
   logic              err_next;

   // Register 0 never sees an enable when hardwired, so it stays at reset value.
   always_comb begin
      wr_hit  = '0;
      rsv_hit = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         if (!(ZERO_R0 && i == 0)) begin
            wr_hit[i]  = wr_en  && (wr_sel  == AW'(i));
            rsv_hit[i] = rsv_en && (rsv_sel == AW'(i));
         end
      end
   end

   for (genvar g = 0; g < NREGS; g++) begin : g_entry
      rf_sb_entry #(
         .DATA_W (DATA_W)
      ) u_entry (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr      (wr_hit[g]),
         .rsv     (rsv_hit[g]),
         .wr_data (wr_data),
         .data    (regs[g]),
         .pend    (pend_bits[g])
      );
   end

   assign byp1 = wr_en && (wr_sel == rd1_sel);
   assign byp2 = wr_en && (wr_sel == rd2_sel);

   assign rd1_data = (ZERO_R0 && rd1_sel == '0) ? '0 : (byp1 ? wr_data : regs[rd1_sel]);
   assign rd2_data = (ZERO_R0 && rd2_sel == '0) ? '0 : (byp2 ? wr_data : regs[rd2_sel]);

   assign rd1_pend = pend_bits[rd1_sel] & ~byp1;
   assign rd2_pend = pend_bits[rd2_sel] & ~byp2;

   assign pend_vec = pend_bits;

   assign wr_ok  = !(ZERO_R0 && wr_sel  == '0);
   assign rsv_ok = !(ZERO_R0 && rsv_sel == '0);

   // Both error causes OR into one pulse.
   assign err_next = (wr_en && wr_ok && !pend_bits[wr_sel]) ||
                     (rsv_en && rsv_ok && pend_bits[rsv_sel] &&
                      !(wr_en && wr_sel == rsv_sel));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err <= 1'b0;
      else        err <= err_next;
   end

endmodule

// File: doc/rf_sb.md
RF_SB -- requirements
Module: rf_sb

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the register data width.
REQ-002 Parameter NREGS, default 8, SHALL set the register count (power of two, at least 2); AW = clog2(NREGS).
REQ-003 Parameter ZERO_R0, default 0, SHALL make register 0 hardwired to zero when set to 1.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 rd1_sel, rd2_sel  in  AW  SHALL select the register for read ports 1 and 2.
REQ-007 rd1_data, rd2_data  out  DATA_W  SHALL carry the read data for ports 1 and 2.
REQ-008 rd1_pend, rd2_pend  out  1  SHALL indicate that the selected register awaits an outstanding write.
REQ-009 wr_en, wr_sel, wr_data  in  1/AW/DATA_W  SHALL form the write port.
REQ-010 rsv_en, rsv_sel  in  1/AW  SHALL form the reservation port (issue marks destination pending).
REQ-011 pend_vec  out  NREGS  SHALL expose all pending bits, registered.
REQ-012 err  out  1  SHALL be a registered one-cycle protocol-error pulse.

Function
REQ-013 Reads SHALL be combinational: rdN_data = reg[rdN_sel].
REQ-014 Bypass: if wr_en and wr_sel == rdN_sel in the same cycle, rdN_data SHALL equal wr_data (zero-latency write-to-read forwarding).
REQ-015 A write SHALL update reg[wr_sel] at the next rising edge; data latency is 1 cycle, bypass latency 0.
REQ-016 Reservation: rsv_en SHALL set pending[rsv_sel] at the next edge.
REQ-017 Write completion: wr_en SHALL clear pending[wr_sel] at the next edge.
REQ-018 Simultaneous write and reserve to the same register SHALL leave pending set (the new producer wins); the data is still written.
REQ-019 rdN_pend = pending[rdN_sel] AND NOT (wr_en and wr_sel == rdN_sel); a write in flight SHALL hide the pending bit that cycle.
REQ-020 err SHALL pulse for one cycle after either event:
- wr_en to a non-pending register;
- rsv_en to a register that is pending and not being written in the same cycle.
REQ-021 Both err causes in one cycle SHALL yield a single pulse; the offending operation still takes effect.
REQ-022 With ZERO_R0=1, register 0 SHALL always:
- read 0, including during bypass;
- ignore writes;
- never be pending, with rsv to 0 ignored and no err for writes or reservations to 0.
REQ-023 With ZERO_R0=0, register 0 SHALL behave like every other register.
REQ-024 Two read ports SHALL resolve independently; both may select the same register.

Reset
REQ-025 On rst_n low, asynchronously, all registers, pending bits, pend_vec and err SHALL clear to 0.
REQ-026 Reset asserted mid-operation SHALL discard in-flight writes and reservations; the first edge after deassertion SHALL act normally.
REQ-027 While in reset, read data outputs SHALL reflect cleared contents, with bypass still active combinationally.

Structure
REQ-028 Package rf_pkg SHALL hold the DATA_W and NREGS defaults and an AW computation helper.
REQ-029 One sub-module, rf_sb_entry, SHALL hold one register: data flop, pending flop, and write/reserve enables.
REQ-030 rf_sb SHALL instantiate NREGS rf_sb_entry instances in a generate loop, plus the decode, bypass and error logic.

Verification
REQ-031 Reset, rsv_en sel 3, then wr_en sel 3 data 0xBEEF two cycles later:
- rd1_pend=1 in between;
- the write cycle shows rd1_data=0xBEEF, rd1_pend=0;
- afterwards pend_vec=0.
REQ-032 wr_en sel 5 data 0x1234 with no prior reservation: register written, err=1 for exactly one cycle.
REQ-033 Same cycle rsv_en sel 2 and wr_en sel 2 data 0x00AA, with reg 2 pending: reg2=0x00AA, pend_vec[2] stays 1, err=0.
REQ-034 ZERO_R0=1: wr_en sel 0 data 0xFFFF, rd1_sel=0 → rd1_data=0 in the same and next cycle; rsv_en sel 0 leaves pend_vec=0.
REQ-035 Write 0x5555 to reg 7, reserve reg 7, assert rst_n low asynchronously mid-cycle: reg7=0, pend_vec=0, err=0 immediately.
REQ-036 DATA_W=32, NREGS=16: write 0xDEADBEEF to reg 15 and read back on both ports; reserve reg 15 twice without a write → err pulse.
